// File: rtl/core_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pipe_ctrl: hold/flush/redirect controller for PC, IF/ID and ID/EX.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_pipe_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int REG_W      = 5,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_in,
  input  logic [ADDR_W-1:0] jump_addr_in,
  input  logic [REG_W-1:0]  id_rs1_in,
  input  logic [REG_W-1:0]  id_rs2_in,
  input  logic              id_rs1_used_in,
  input  logic              id_rs2_used_in,
  input  logic              ex_is_load_in,
  input  logic              ex_reg_we_in,
  input  logic [REG_W-1:0]  ex_rd_in,
  input  logic              ex_mc_start_in,
  input  logic              ex_mc_done_in,
  input  logic              bus_stall_in,
  output logic              pc_hold_out,
  output logic              if_id_hold_out,
  output logic              id_ex_hold_out,
  output logic              if_id_flush_out,
  output logic              id_ex_flush_out,
  output logic              pc_jump_out,
  output logic [ADDR_W-1:0] pc_jump_addr_out,
  output logic              mc_timeout_out,
  output logic [CNT_W-1:0]  stall_cnt_out
);

  localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MC_WAIT   = 2'd1,
    ST_JUMP_PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic                mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                w_load_use;
  logic                w_pc_hold, w_if_id_hold, w_id_ex_hold;
  logic                w_if_id_flush, w_id_ex_flush;
  logic                w_pc_jump;
  logic [ADDR_W-1:0]   w_jump_addr;

  assign w_load_use = ex_is_load_in & ex_reg_we_in & (ex_rd_in != '0) &
                      ((id_rs1_used_in & (id_rs1_in == ex_rd_in)) |
                       (id_rs2_used_in & (id_rs2_in == ex_rd_in)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    jaddr_d       = jaddr_q;
    mc_timeout_d  = 1'b0;
    w_pc_hold     = 1'b0;
    w_if_id_hold  = 1'b0;
    w_id_ex_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    // The cycle after a watchdog abort squashes the op that never completed.
    w_id_ex_flush = mc_timeout_q;
    w_pc_jump     = 1'b0;
    w_jump_addr   = '0;

    case (state_q)
      ST_RUN: begin
        if (bus_stall_in && jump_req_in) begin
          jaddr_d      = jump_addr_in;
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
          state_d      = ST_JUMP_PEND;
        end else if (bus_stall_in) begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
        end else if (jump_req_in) begin
          w_pc_jump     = 1'b1;
          w_jump_addr   = jump_addr_in;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (ex_mc_start_in && !ex_mc_done_in) begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
          wait_cnt_d   = WAIT_W'(1);
          state_d      = ST_MC_WAIT;
        end else if (w_load_use) begin
          w_pc_hold     = 1'b1;
          w_if_id_hold  = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end

      ST_MC_WAIT: begin
        if (ex_mc_done_in) begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
          if (wait_cnt_q == C_WAIT_LAST) begin
            mc_timeout_d = 1'b1;
            wait_cnt_d   = '0;
            state_d      = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end

      ST_JUMP_PEND: begin
        w_jump_addr = jaddr_q;
        if (bus_stall_in) begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
        end else begin
          w_pc_jump     = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          state_d       = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign pc_hold_out      = w_pc_hold;
  assign if_id_hold_out   = w_if_id_hold & ~w_if_id_flush;
  assign id_ex_hold_out   = w_id_ex_hold & ~w_id_ex_flush;
  assign if_id_flush_out  = w_if_id_flush;
  assign id_ex_flush_out  = w_id_ex_flush;
  assign pc_jump_out      = w_pc_jump;
  assign pc_jump_addr_out = w_jump_addr;
  assign mc_timeout_out   = mc_timeout_q;
  assign stall_cnt_out    = stall_cnt_q;

  assign stall_cnt_d = (pc_hold_out && (stall_cnt_q != C_CNT_MAX)) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      wait_cnt_q   <= '0;
      jaddr_q      <= '0;
      mc_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      jaddr_q      <= jaddr_d;
      mc_timeout_q <= mc_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_pipe_ctrl: directed self-checking bench for core_pipe_ctrl.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_core_pipe_ctrl;

  localparam int REG_W  = 5;
  localparam int ADDR_W = 32;

  // Control vector layout: {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, pc_jump, mc_timeout}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_HOLD3 = 7'b1110000;
  localparam logic [6:0] C_JUMP  = 7'b0001110;
  localparam logic [6:0] C_LU    = 7'b1100100;
  localparam logic [6:0] C_TO    = 7'b0000101;

  logic              clk = 1'b0;
  logic              rst;
  logic              jump_req_in;
  logic [ADDR_W-1:0] jump_addr_in;
  logic [REG_W-1:0]  id_rs1_in, id_rs2_in, ex_rd_in;
  logic              id_rs1_used_in, id_rs2_used_in;
  logic              ex_is_load_in, ex_reg_we_in;
  logic              ex_mc_start_in, ex_mc_done_in, bus_stall_in;

  logic              pc_hold_out, if_id_hold_out, id_ex_hold_out;
  logic              if_id_flush_out, id_ex_flush_out, pc_jump_out, mc_timeout_out;
  logic [ADDR_W-1:0] pc_jump_addr_out;
  logic [31:0]       stall_cnt_out;

  logic              s_pc_hold, s_if_id_hold, s_id_ex_hold;
  logic              s_if_id_flush, s_id_ex_flush, s_pc_jump, s_mc_timeout;
  logic [ADDR_W-1:0] s_jump_addr;
  logic [3:0]        s_stall_cnt;

  logic [6:0]        ctl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_hold_out, if_id_hold_out, id_ex_hold_out, if_id_flush_out,
                id_ex_flush_out, pc_jump_out, mc_timeout_out};

  core_pipe_ctrl #(.MC_TIMEOUT(8), .REG_W(REG_W), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .jump_req_in(jump_req_in), .jump_addr_in(jump_addr_in),
    .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
    .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
    .ex_is_load_in(ex_is_load_in), .ex_reg_we_in(ex_reg_we_in), .ex_rd_in(ex_rd_in),
    .ex_mc_start_in(ex_mc_start_in), .ex_mc_done_in(ex_mc_done_in),
    .bus_stall_in(bus_stall_in),
    .pc_hold_out(pc_hold_out), .if_id_hold_out(if_id_hold_out), .id_ex_hold_out(id_ex_hold_out),
    .if_id_flush_out(if_id_flush_out), .id_ex_flush_out(id_ex_flush_out),
    .pc_jump_out(pc_jump_out), .pc_jump_addr_out(pc_jump_addr_out),
    .mc_timeout_out(mc_timeout_out), .stall_cnt_out(stall_cnt_out)
  );

  // Narrow counter instance, used to observe saturation.
  core_pipe_ctrl #(.MC_TIMEOUT(8), .REG_W(REG_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .jump_req_in(jump_req_in), .jump_addr_in(jump_addr_in),
    .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
    .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
    .ex_is_load_in(ex_is_load_in), .ex_reg_we_in(ex_reg_we_in), .ex_rd_in(ex_rd_in),
    .ex_mc_start_in(ex_mc_start_in), .ex_mc_done_in(ex_mc_done_in),
    .bus_stall_in(bus_stall_in),
    .pc_hold_out(s_pc_hold), .if_id_hold_out(s_if_id_hold), .id_ex_hold_out(s_id_ex_hold),
    .if_id_flush_out(s_if_id_flush), .id_ex_flush_out(s_id_ex_flush),
    .pc_jump_out(s_pc_jump), .pc_jump_addr_out(s_jump_addr),
    .mc_timeout_out(s_mc_timeout), .stall_cnt_out(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    jump_req_in    = 1'b0;
    jump_addr_in   = '0;
    id_rs1_in      = '0;
    id_rs2_in      = '0;
    id_rs1_used_in = 1'b0;
    id_rs2_used_in = 1'b0;
    ex_is_load_in  = 1'b0;
    ex_reg_we_in   = 1'b0;
    ex_rd_in       = '0;
    ex_mc_start_in = 1'b0;
    ex_mc_done_in  = 1'b0;
    bus_stall_in   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    #12;
    chk("reset_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    chk("reset_cnt", stall_cnt_out, 32'd0);
    chk("reset_addr", pc_jump_addr_out, 32'd0);
    chk("reset_sat_cnt", {28'd0, s_stall_cnt}, 32'd0);
    step();
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      settle();
      chk("idle_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
      chk("idle_cnt", stall_cnt_out, 32'd0);
      step();
    end

    // Taken jump in RUN
    jump_req_in  = 1'b1;
    jump_addr_in = 32'h0000_0100;
    settle();
    chk("jump_ctl", {25'd0, ctl}, {25'd0, C_JUMP});
    chk("jump_addr", pc_jump_addr_out, 32'h0000_0100);
    step();
    clear_in();
    settle();
    chk("jump_after_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();

    // Load-use on rs2
    ex_is_load_in  = 1'b1;
    ex_reg_we_in   = 1'b1;
    ex_rd_in       = 5'd5;
    id_rs2_in      = 5'd5;
    id_rs2_used_in = 1'b1;
    settle();
    chk("lu_rs2_ctl", {25'd0, ctl}, {25'd0, C_LU});
    step();
    clear_in();
    settle();
    chk("lu_after_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    chk("lu_cnt", stall_cnt_out, 32'd1);
    step();

    // rd=x0 never stalls
    ex_is_load_in  = 1'b1;
    ex_reg_we_in   = 1'b1;
    ex_rd_in       = 5'd0;
    id_rs2_in      = 5'd0;
    id_rs2_used_in = 1'b1;
    settle();
    chk("lu_x0_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();

    // Matching rs1 that is not read: no stall; then read: stall
    clear_in();
    ex_is_load_in = 1'b1;
    ex_reg_we_in  = 1'b1;
    ex_rd_in      = 5'd7;
    id_rs1_in     = 5'd7;
    settle();
    chk("lu_rs1_unused_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();
    id_rs1_used_in = 1'b1;
    settle();
    chk("lu_rs1_ctl", {25'd0, ctl}, {25'd0, C_LU});
    step();
    clear_in();
    settle();
    chk("lu_rs1_cnt", stall_cnt_out, 32'd2);
    step();

    // Multi-cycle op completing 4 cycles after start; a jump mid-wait is ignored
    ex_mc_start_in = 1'b1;
    settle();
    chk("mc_c0_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
    step();
    ex_mc_start_in = 1'b0;
    for (int i = 1; i < 4; i++) begin
      jump_req_in  = (i == 3);
      jump_addr_in = 32'h0000_0dea;
      settle();
      chk("mc_wait_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
      step();
    end
    clear_in();
    ex_mc_done_in = 1'b1;
    settle();
    chk("mc_done_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();
    clear_in();
    settle();
    chk("mc_done_cnt", stall_cnt_out, 32'd6);
    chk("mc_after_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();

    // Watchdog: no done within 8 cycles
    ex_mc_start_in = 1'b1;
    settle();
    chk("to_c0_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
    step();
    ex_mc_start_in = 1'b0;
    for (int i = 1; i < 8; i++) begin
      settle();
      chk("to_wait_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
      step();
    end
    settle();
    chk("to_pulse_ctl", {25'd0, ctl}, {25'd0, C_TO});
    chk("to_cnt", stall_cnt_out, 32'd14);
    step();
    settle();
    chk("to_after_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();

    // Jump under bus stall: first jump wins
    bus_stall_in = 1'b1;
    jump_req_in  = 1'b1;
    jump_addr_in = 32'h0000_0200;
    settle();
    chk("bj_c1_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
    step();
    jump_addr_in = 32'h0000_0300;
    settle();
    chk("bj_c2_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
    chk("bj_c2_addr", pc_jump_addr_out, 32'h0000_0200);
    step();
    jump_req_in = 1'b0;
    settle();
    chk("bj_c3_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
    step();
    bus_stall_in = 1'b0;
    settle();
    chk("bj_c4_ctl", {25'd0, ctl}, {25'd0, C_JUMP});
    chk("bj_c4_addr", pc_jump_addr_out, 32'h0000_0200);
    step();
    settle();
    chk("bj_after_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    chk("bj_cnt", stall_cnt_out, 32'd17);
    step();

    // Asynchronous reset in the middle of a multi-cycle wait
    ex_mc_start_in = 1'b1;
    step();
    ex_mc_start_in = 1'b0;
    settle();
    chk("rst_pre_ctl", {25'd0, ctl}, {25'd0, C_HOLD3});
    chk("rst_pre_cnt", stall_cnt_out, 32'd18);
    rst = 1'b0;
    #1;
    chk("rst_async_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    chk("rst_async_cnt", stall_cnt_out, 32'd0);
    step();
    rst = 1'b1;
    settle();
    chk("rst_release_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
    step();

    // Saturation of the 4-bit counter under a long bus stall
    bus_stall_in = 1'b1;
    for (int i = 0; i < 15; i++) step();
    settle();
    chk("sat_reach", {28'd0, s_stall_cnt}, 32'h0000_000f);
    for (int i = 0; i < 5; i++) step();
    bus_stall_in = 1'b0;
    settle();
    chk("sat_hold", {28'd0, s_stall_cnt}, 32'h0000_000f);
    chk("sat_wide_cnt", stall_cnt_out, 32'd20);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
